dcache_refill_ctrl: RTL

DCACHE_REFILL_CTRL -- requirements
Module: dcache_refill_ctrl

---
 rtl/dcache_refill_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill controller: optional dirty-victim writeback, then block read, then one-cycle fill.
// One miss in flight at a time; a read with an immediate response fills three cycles after miss accept.

package dcache_refill_pkg;
  localparam int BLOCK_ADDR_W = 26;
  localparam int BLOCK_DATA_W = 128;

  typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
  typedef logic [BLOCK_DATA_W-1:0] block_data_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_type_t;
endpackage

module dcache_refill_ctrl
  import dcache_refill_pkg::*;
#(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_aL,

  input  logic                 miss_valid,
  output logic                 miss_ready,
  input  main_mem_block_addr_t miss_block_addr,
  input  logic                 miss_wb_needed,
  input  main_mem_block_addr_t miss_wb_block_addr,
  input  block_data_t          miss_wb_block_data,

  output logic                 fill_valid,
  output main_mem_block_addr_t fill_block_addr,
  output block_data_t          fill_block_data,

  output logic                 mem_ctrl_req_valid,
  output req_type_t            mem_ctrl_req_type,
  output main_mem_block_addr_t mem_ctrl_req_block_addr,
  output block_data_t          mem_ctrl_req_block_data,
  input  logic                 mem_ctrl_req_ready,

  input  logic                 mem_ctrl_resp_valid,
  input  block_data_t          mem_ctrl_resp_block_data,

  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    FILL    = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(RESP_TIMEOUT);

  state_t               state;
  state_t               state_n;

  main_mem_block_addr_t miss_addr_q;
  main_mem_block_addr_t wb_addr_q;
  block_data_t          wb_data_q;
  block_data_t          resp_data_q;
  logic [15:0]          wait_cnt;
  logic [15:0]          wait_cnt_inc;

  logic                 miss_accept;
  logic                 rd_accept;
  logic                 resp_accept;
  logic                 wait_idle_cycle;

  assign miss_accept     = (state == IDLE) && miss_valid;
  assign rd_accept       = (state == RD_REQ) && mem_ctrl_req_ready;
  // Responses are only meaningful while waiting; anything else is dropped.
  assign resp_accept     = (state == RD_WAIT) && mem_ctrl_resp_valid;
  assign wait_idle_cycle = (state == RD_WAIT) && !mem_ctrl_resp_valid;
  assign wait_cnt_inc    = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n                 = state;
    miss_ready              = 1'b0;
    fill_valid              = 1'b0;
    fill_block_addr         = '0;
    fill_block_data         = '0;
    mem_ctrl_req_valid      = 1'b0;
    mem_ctrl_req_type       = READ;
    mem_ctrl_req_block_addr = '0;
    mem_ctrl_req_block_data = '0;

    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          state_n = miss_wb_needed ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        mem_ctrl_req_valid      = 1'b1;
        mem_ctrl_req_type       = WRITE;
        mem_ctrl_req_block_addr = wb_addr_q;
        mem_ctrl_req_block_data = wb_data_q;
        if (mem_ctrl_req_ready) begin
          state_n = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_ctrl_req_valid      = 1'b1;
        mem_ctrl_req_type       = READ;
        mem_ctrl_req_block_addr = miss_addr_q;
        if (mem_ctrl_req_ready) begin
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_ctrl_resp_valid) begin
          state_n = FILL;
        end
      end
      FILL: begin
        fill_valid      = 1'b1;
        fill_block_addr = miss_addr_q;
        fill_block_data = resp_data_q;
        state_n         = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      resp_data_q <= '0;
    end else begin
      if (miss_accept) begin
        miss_addr_q <= miss_block_addr;
        wb_addr_q   <= miss_wb_block_addr;
        wb_data_q   <= miss_wb_block_data;
      end
      if (resp_accept) begin
        resp_data_q <= mem_ctrl_resp_block_data;
      end
    end
  end

  // Counter measures idle cycles of the current read only; the error flag is sticky.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (rd_accept) begin
        wait_cnt <= '0;
      end else if (wait_idle_cycle) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == TIMEOUT_CNT) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
